instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 18 +
 rtl/instr_loader_word_assembler.sv | 43 ++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types for the instruction loader. The CSUM state exists only when
// INSTR_LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word shifter with a 2-bit wrapping byte counter.
// word_next/last are combinational so the loader can act on the 4th byte's edge.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        accept,
  input  logic                        emit,
  input  logic [7:0]                  byte_data,
  output logic [8*BYTES_PER_WORD-1:0] word_next,
  output logic                        last,
  output logic                        word_valid
);

  localparam int W = 8 * BYTES_PER_WORD;

  logic [1:0]   cnt_reg;
  logic [W-1:0] shift_reg;

  // Newest byte enters at the top, so the first byte ends up in bits [7:0].
  assign word_next = {byte_data, shift_reg[W-1:8]};
  assign last      = accept && (cnt_reg == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= 2'd0;
      shift_reg  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last && emit;
      if (clr) begin
        cnt_reg   <= 2'd0;
        shift_reg <= '0;
      end else if (accept) begin
        cnt_reg   <= cnt_reg + 2'd1;
        shift_reg <= word_next;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed program into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte is enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH_WORDS   = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  localparam int KW = $clog2(DEPTH_WORDS + 1);

  state_t                      state;
  logic [KW-1:0]               word_idx;
  logic [KW-1:0]               word_cnt;
  logic [KW-1:0]               idx_inc;
  logic                        accept;
  logic                        start_ok;
  logic                        last;
  logic [8*BYTES_PER_WORD-1:0] word_next;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]                  csum_reg;
`endif

  assign accept   = byte_valid && byte_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
  assign idx_inc  = word_idx + KW'(1);

  // The assembler's registered word_valid is exactly the one-cycle write strobe.
  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .accept     (accept),
    .emit       (state == DATA),
    .byte_data  (byte_data),
    .word_next  (word_next),
    .last       (last),
    .word_valid (mem_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
      word_idx   <= '0;
      word_cnt   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_reg   <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN;
            byte_ready <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            word_idx   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_reg   <= 8'h00;
`endif
          end
        end

        LEN: begin
          if (last) begin
            if (word_next == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state      <= CSUM;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else if (word_next > DEPTH_WORDS) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              err        <= 1'b1;
            end else begin
              state    <= DATA;
              word_cnt <= word_next[KW-1:0];
            end
          end
        end

        DATA: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (accept) csum_reg <= csum_reg ^ byte_data;
`endif
          if (last) begin
            mem_addr  <= BASE_ADDR + (ADDRESS_WIDTH'(word_idx) << 2);
            mem_wdata <= word_next;
            word_idx  <= idx_inc;
            if (idx_inc == word_cnt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state      <= CSUM;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum_reg) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader; covers the checksum scenarios when
// INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  int writes_before;

  logic [63:0] exp_q[$];
  logic [7:0]  tx[$];
  logic [31:0] words[$];
  logic [7:0]  csum_flip = 8'h00;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [63:0] e;
      writes++;
      $display("write addr=%08h data=%08h", mem_addr, mem_wdata);
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
        check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  // Build header, data bytes and (optionally) checksum from words[]; queue expected writes.
  task automatic prep();
    logic [7:0] x;
    int n;
    x = 8'h00;
    n = words.size();
    tx.delete();
    for (int i = 0; i < 4; i++) tx.push_back(8'(n >> (8 * i)));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] b;
        b = words[i][8*j +: 8];
        tx.push_back(b);
        x = x ^ b;
      end
      exp_q.push_back({32'(4 * i), words[i]});
    end
    x = x ^ csum_flip;
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx.push_back(x);
`endif
    $display("load %0d words, checksum byte %02h", n, x);
  endtask

  task automatic send_n(input int count);
    logic [7:0] b;
    for (int k = 0; k < count && tx.size() > 0; k++) begin
      int t;
      byte_valid = 1'b1;
      byte_data  = tx[0];
      t = 0;
      @(negedge clk);
      while (!byte_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'd1);
      @(posedge clk);
      #1;
      b = tx.pop_front();
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!(done || err)) check("end_timeout", 64'(done | err), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic two_word_load(input string tag);
    words = '{32'h00100513, 32'h00200593};
    csum_flip = 8'h00;
    prep();
    writes_before = writes;
    pulse_start();
    check({tag, "_len_ready"}, 64'(byte_ready), 64'd1);
    check({tag, "_len_hold"}, 64'(cpu_hold), 64'd1);
    send_n(100);
    wait_end();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_writes"}, 64'(writes - writes_before), 64'd2);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_addr_hold"}, 64'(mem_addr), 64'h4);
    check({tag, "_data_hold"}, 64'(mem_wdata), 64'h00200593);
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    two_word_load("two_word");

    // Empty program
    words.delete();
    csum_flip = 8'h00;
    prep();
    writes_before = writes;
    pulse_start();
    send_n(100);
    wait_end();
    check("empty_done", 64'(done), 64'd1);
    check("empty_hold", 64'(cpu_hold), 64'd0);
    check("empty_writes", 64'(writes - writes_before), 64'd0);

    // Oversize header N=257
    tx = '{8'h01, 8'h01, 8'h00, 8'h00};
    writes_before = writes;
    pulse_start();
    send_n(4);
    wait_end();
    check("over_err", 64'(err), 64'd1);
    check("over_done", 64'(done), 64'd0);
    check("over_hold", 64'(cpu_hold), 64'd1);
    check("over_ready", 64'(byte_ready), 64'd0);
    check("over_writes", 64'(writes - writes_before), 64'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Wrong checksum after one word: the write stays, loader ends in error
    words = '{32'hDDCCBBAA};
    csum_flip = 8'h5A;
    prep();
    writes_before = writes;
    pulse_start();
    send_n(100);
    wait_end();
    check("csum_err", 64'(err), 64'd1);
    check("csum_done", 64'(done), 64'd0);
    check("csum_hold", 64'(cpu_hold), 64'd1);
    check("csum_writes", 64'(writes - writes_before), 64'd1);
    csum_flip = 8'h00;
`endif

    // Stall mid-word with an ignored start pulse
    words = '{32'hCAFEF00D};
    prep();
    writes_before = writes;
    pulse_start();
    send_n(6);
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check("stall_ready", 64'(byte_ready), 64'd1);
    check("stall_done", 64'(done), 64'd0);
    check("stall_err", 64'(err), 64'd0);
    send_n(100);
    wait_end();
    check("stall_final_done", 64'(done), 64'd1);
    check("stall_writes", 64'(writes - writes_before), 64'd1);
    check("stall_pending", 64'(exp_q.size()), 64'd0);

    // Reset in DATA after two data bytes
    words = '{32'h11223344, 32'h55667788};
    prep();
    writes_before = writes;
    pulse_start();
    send_n(6);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(byte_ready), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_we", 64'(mem_we), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    tx.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_writes", 64'(writes - writes_before), 64'd0);
    two_word_load("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
